// File: rtl/regunit_skew_if.sv
// Lane-packed data and control bundle for regunit_skew; lane k sits at [k*B +: B].
interface regunit_skew_if #(
  parameter int unsigned B = 8,
  parameter int unsigned L = 4
);
  logic [L*B-1:0] in0;
  logic [L*B-1:0] in1;
  logic           stop_in;
  logic           slc_in;
  logic           valid_in;
  logic [L*B-1:0] out;
  logic [L*B-1:0] regval;
  logic [L-1:0]   valid_out;
  logic [L-1:0]   stop_out;

  modport master (
    output in0, in1, stop_in, slc_in, valid_in,
    input  out, regval, valid_out, stop_out
  );

  modport slave (
    input  in0, in1, stop_in, slc_in, valid_in,
    output out, regval, valid_out, stop_out
  );
endinterface

// File: rtl/regunit_skew.sv
// Multi-lane stream/hold/side-load input register with a k-cycle skew on lane k,
// forwarding reset and stop to each PE row aligned with that row's data.
module regunit_skew #(
  parameter int unsigned B = 8,
  parameter int unsigned L = 4
) (
  input  logic         clk,
  input  logic         rst_in,
  output logic [L-1:0] rst_out,
  regunit_skew_if.slave bus
);

  logic [L-1:0] w_d_stop;
  logic [L-1:0] w_d_slc;
  logic [L-1:0] w_d_valid;
  logic [L-1:0] r_stop_out;
  logic [L-1:0] r_rst_out;

  assign w_d_stop[0]  = bus.stop_in;
  assign w_d_slc[0]   = bus.slc_in;
  assign w_d_valid[0] = bus.valid_in;

  // Shared control delay line; bit j carries the controls delayed j+1 cycles.
  if (L > 1) begin : g_ctl
    localparam int unsigned DW = L - 1;
    logic [DW-1:0] r_stop_dl;
    logic [DW-1:0] r_slc_dl;
    logic [DW-1:0] r_valid_dl;

    always_ff @(posedge clk) begin
      if (rst_in) begin
        r_stop_dl  <= '0;
        r_slc_dl   <= '0;
        r_valid_dl <= '0;
      end else begin
        r_stop_dl  <= DW'({r_stop_dl, bus.stop_in});
        r_slc_dl   <= DW'({r_slc_dl, bus.slc_in});
        r_valid_dl <= DW'({r_valid_dl, bus.valid_in});
      end
    end

    assign w_d_stop[L-1:1]  = r_stop_dl;
    assign w_d_slc[L-1:1]   = r_slc_dl;
    assign w_d_valid[L-1:1] = r_valid_dl;
  end

  for (genvar k = 0; k < L; k++) begin : g_lane
    logic [B-1:0] w_in0;
    logic [B-1:0] w_in1;
    logic [B-1:0] w_d_in0;
    logic [B-1:0] w_d_in1;
    logic [B-1:0] w_out;
    logic [B-1:0] r_regval;

    assign w_in0 = bus.in0[k*B +: B];
    assign w_in1 = bus.in1[k*B +: B];

    if (k == 0) begin : g_direct
      assign w_d_in0 = w_in0;
      assign w_d_in1 = w_in1;
    end else begin : g_dly
      localparam int unsigned DW = k * B;
      logic [k-1:0][B-1:0] r_in0_dl;
      logic [k-1:0][B-1:0] r_in1_dl;

      always_ff @(posedge clk) begin
        if (rst_in) begin
          r_in0_dl <= '0;
          r_in1_dl <= '0;
        end else begin
          r_in0_dl <= DW'({r_in0_dl, w_in0});
          r_in1_dl <= DW'({r_in1_dl, w_in1});
        end
      end

      assign w_d_in0 = r_in0_dl[k-1];
      assign w_d_in1 = r_in1_dl[k-1];
    end

    assign w_out = w_d_stop[k] ? (w_d_slc[k] ? w_d_in1 : r_regval) : w_d_in0;

    always_ff @(posedge clk) begin
      if (rst_in) begin
        r_regval <= '0;
      end else begin
        r_regval <= w_out;
      end
    end

    assign bus.out[k*B +: B]    = w_out;
    assign bus.regval[k*B +: B] = r_regval;
  end

  // Stop is cleared by reset; the reset chain itself only shifts.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      r_stop_out <= '0;
    end else begin
      r_stop_out <= w_d_stop;
    end
    r_rst_out <= L'({r_rst_out, rst_in});
  end

  assign bus.stop_out  = r_stop_out;
  assign bus.valid_out = w_d_valid;
  assign rst_out       = r_rst_out;

endmodule

// File: tb/tb_regunit_skew.sv
// Directed checks of regunit_skew (L=4, B=8) plus a randomised L=1, B=16 run
// against a single-lane reference.
module tb_regunit_skew;

  logic       clk = 1'b0;
  logic       rst4;
  logic       rst1;
  logic [3:0] rso4;
  logic [0:0] rso1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regunit_skew_if #(.B(8),  .L(4)) b4 ();
  regunit_skew_if #(.B(16), .L(1)) b1 ();

  regunit_skew #(.B(8), .L(4)) u_dut4 (
    .clk     (clk),
    .rst_in  (rst4),
    .rst_out (rso4),
    .bus     (b4.slave)
  );

  regunit_skew #(.B(16), .L(1)) u_dut1 (
    .clk     (clk),
    .rst_in  (rst1),
    .rst_out (rso1),
    .bus     (b1.slave)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pack_stream(input int t);
    logic [31:0] v;
    for (int k = 0; k < 4; k++) v[k*8 +: 8] = 8'(16 * t + k);
    return v;
  endfunction

  function automatic bit stop_a(input int c);
    return (c >= 10 && c <= 12) || (c >= 20 && c <= 25);
  endfunction

  // Expected lane-k output in phase A (stream, hold 10..12, side-load 20 then hold to 25).
  function automatic logic [7:0] exp_a(input int k, input int t);
    int s;
    s = t - k;
    if (s < 0) return 8'h00;
    if (s >= 10 && s <= 12) return 8'(144 + k);
    if (s >= 20 && s <= 25) return 8'(160 + k);
    return 8'(16 * s + k);
  endfunction

  // Expected lane-k output in phase B (hold from 10, reset pulse in 11).
  function automatic logic [7:0] exp_b(input int k, input int u);
    int s;
    s = u - k;
    if (u <= 11) begin
      if (s < 0) return 8'h00;
      if (s >= 10) return 8'(144 + k);
      return 8'(16 * s + k);
    end
    if (s >= 12) return 8'(16 * s + k);
    return 8'h00;
  endfunction

  function automatic bit rst_b(input int c);
    return (c == -2) || (c == -1) || (c == 11);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0]  rst_tab [5];
    logic [3:0]  e_bits;
    logic [3:0]  e_stop;
    logic [3:0]  e_rst;
    logic [31:0] side;
    logic [15:0] m_reg, m_out;
    logic        m_stop_q, m_rst_q;

    rst_tab[0] = 4'b0011;
    rst_tab[1] = 4'b0110;
    rst_tab[2] = 4'b1100;
    rst_tab[3] = 4'b1000;
    rst_tab[4] = 4'b0000;
    side = 32'hA3A2A1A0;

    rst4 = 1'b0;
    b4.in0 = '1; b4.in1 = '0; b4.stop_in = 1'b0; b4.slc_in = 1'b0; b4.valid_in = 1'b1;
    rst1 = 1'b1;
    b1.in0 = '0; b1.in1 = '0; b1.stop_in = 1'b0; b1.slc_in = 1'b0; b1.valid_in = 1'b0;
    repeat (5) next_cycle();

    // Phase A: two reset cycles, then stream / hold / side-load.
    rst4 = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("rst.out0", 64'(b4.out[7:0]), 64'h0FF);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst.regval k%0d", k), 64'(b4.regval[k*8 +: 8]), 64'h0);
      if (k > 0) chk($sformatf("rst.out k%0d", k), 64'(b4.out[k*8 +: 8]), 64'h0);
    end
    chk("rst.valid_out[3:1]", 64'(b4.valid_out[3:1]), 64'h0);
    chk("rst.stop_out", 64'(b4.stop_out), 64'h0);
    chk("rst.rst_out", 64'(rso4), 64'h1);
    next_cycle();

    for (int t = 0; t <= 32; t++) begin
      rst4 = 1'b0;
      b4.in0 = pack_stream(t);
      b4.in1 = (t == 20) ? side : 32'h55555555;
      b4.stop_in = stop_a(t);
      b4.slc_in = (t == 20);
      b4.valid_in = 1'b1;
      @(negedge clk);
      e_bits = '0;
      e_stop = '0;
      for (int k = 0; k < 4; k++) begin
        e_bits[k] = (t >= k);
        e_stop[k] = (t - k - 1 >= 0) && stop_a(t - k - 1);
        chk($sformatf("A.out t%0d k%0d", t, k), 64'(b4.out[k*8 +: 8]), 64'(exp_a(k, t)));
        chk($sformatf("A.regval t%0d k%0d", t, k), 64'(b4.regval[k*8 +: 8]),
            (t == 0) ? 64'h0 : 64'(exp_a(k, t - 1)));
      end
      chk($sformatf("A.valid_out t%0d", t), 64'(b4.valid_out), 64'(e_bits));
      chk($sformatf("A.stop_out t%0d", t), 64'(b4.stop_out), 64'(e_stop));
      chk($sformatf("A.rst_out t%0d", t), 64'(rso4), (t <= 4) ? 64'(rst_tab[t]) : 64'h0);
      next_cycle();
    end

    // Phase B: reset, stream, hold from cycle 10, single reset pulse in cycle 11.
    rst4 = 1'b1;
    b4.in0 = '1; b4.in1 = '0; b4.stop_in = 1'b0; b4.slc_in = 1'b0; b4.valid_in = 1'b1;
    next_cycle();
    next_cycle();
    for (int u = 0; u <= 17; u++) begin
      rst4 = (u == 11);
      b4.in0 = pack_stream(u);
      b4.in1 = 32'h55555555;
      b4.stop_in = (u == 10) || (u == 11);
      b4.slc_in = 1'b0;
      b4.valid_in = 1'b1;
      @(negedge clk);
      e_bits = '0;
      e_stop = '0;
      e_rst = '0;
      for (int k = 0; k < 4; k++) begin
        if (u <= 11) begin
          e_bits[k] = (u >= k);
          e_stop[k] = (u - k - 1 >= 10);
        end else begin
          e_bits[k] = (k == 0) || (u - k >= 12);
        end
        e_rst[k] = rst_b(u - k - 1);
        chk($sformatf("B.out u%0d k%0d", u, k), 64'(b4.out[k*8 +: 8]), 64'(exp_b(k, u)));
        chk($sformatf("B.regval u%0d k%0d", u, k), 64'(b4.regval[k*8 +: 8]),
            (u == 0 || u == 12) ? 64'h0 : 64'(exp_b(k, u - 1)));
      end
      chk($sformatf("B.valid_out u%0d", u), 64'(b4.valid_out), 64'(e_bits));
      chk($sformatf("B.stop_out u%0d", u), 64'(b4.stop_out), 64'(e_stop));
      chk($sformatf("B.rst_out u%0d", u), 64'(rso4), 64'(e_rst));
      next_cycle();
    end

    // Phase C: single-lane B=16 instance against a reference register.
    m_reg = '0;
    m_stop_q = 1'b0;
    m_rst_q = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      rst1 = ($urandom_range(0, 39) == 0);
      b1.in0 = 16'($urandom);
      b1.in1 = 16'($urandom);
      b1.stop_in = 1'($urandom);
      b1.slc_in = 1'($urandom);
      b1.valid_in = 1'($urandom);
      @(negedge clk);
      m_out = b1.stop_in ? (b1.slc_in ? b1.in1 : m_reg) : b1.in0;
      chk($sformatf("C.out n%0d", n), 64'(b1.out), 64'(m_out));
      chk($sformatf("C.regval n%0d", n), 64'(b1.regval), 64'(m_reg));
      chk($sformatf("C.valid_out n%0d", n), 64'(b1.valid_out), 64'(b1.valid_in));
      chk($sformatf("C.stop_out n%0d", n), 64'(b1.stop_out), 64'(m_stop_q));
      chk($sformatf("C.rst_out n%0d", n), 64'(rso1), 64'(m_rst_q));
      m_reg = rst1 ? 16'h0 : m_out;
      m_stop_q = rst1 ? 1'b0 : b1.stop_in;
      m_rst_q = rst1;
      next_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
